// File: rtl/fixed_shrink_pkg.sv
// fixed_shrink_pkg: shared types and elaboration helpers for the shrink
// activation block.
//   shrink_mode_e    : runtime mode encoding (2'd3 also behaves as bypass)
//   beats_per_tensor : number of input beats that make up one tensor
//   lambda_fix       : real threshold -> fixed-point integer with f frac bits
package fixed_shrink_pkg;

    typedef enum logic [1:0] {
        SHRINK_SOFT   = 2'd0,
        SHRINK_HARD   = 2'd1,
        SHRINK_BYPASS = 2'd2
    } shrink_mode_e;

    function automatic int beats_per_tensor(input int d0, input int d1,
                                            input int p0, input int p1);
        return (d0 / p0) * (d1 / p1);
    endfunction

    function automatic int lambda_fix(input real lam, input int f);
        return $rtoi(lam * $itor(1 << f));
    endfunction

endpackage

// File: rtl/fixed_shrink_if.sv
// fixed_shrink_if: stream + config bundle for fixed_shrink.
//   data_in_0 / valid / ready        : N signed elements of W bits in
//   data_out_0 / valid / ready / last: N results of WO bits out
//   cfg_lambda / cfg_mode / valid / ready : threshold and mode load
// slave = the shrink block, master = whoever drives the stream.
interface fixed_shrink_if #(
    parameter int N  = 1,
    parameter int W  = 8,
    parameter int WO = 8
);
    logic [N-1:0][W-1:0]  data_in_0;
    logic                 data_in_0_valid;
    logic                 data_in_0_ready;
    logic [N-1:0][WO-1:0] data_out_0;
    logic                 data_out_0_valid;
    logic                 data_out_0_ready;
    logic                 data_out_0_last;
    logic [W-1:0]         cfg_lambda;
    logic [1:0]           cfg_mode;
    logic                 cfg_valid;
    logic                 cfg_ready;

    modport slave (
        input  data_in_0, data_in_0_valid, data_out_0_ready,
               cfg_lambda, cfg_mode, cfg_valid,
        output data_in_0_ready, data_out_0, data_out_0_valid,
               data_out_0_last, cfg_ready
    );

    modport master (
        output data_in_0, data_in_0_valid, data_out_0_ready,
               cfg_lambda, cfg_mode, cfg_valid,
        input  data_in_0_ready, data_out_0, data_out_0_valid,
               data_out_0_last, cfg_ready
    );
endinterface

// File: rtl/fixed_shrink_lane.sv
// fixed_shrink_lane: per-element combinational datapath, two independent
// halves that feed the two pipeline registers of the top level.
//   x, lambda, mode -> shr : shrink in W+1-bit signed (stage-1 input)
//   s1              -> y   : F->FO round half-up / left shift, then
//                            saturate to signed WO (stage-2 input)
module fixed_shrink_lane
    import fixed_shrink_pkg::*;
#(
    parameter int W  = 8,
    parameter int F  = 4,
    parameter int WO = 8,
    parameter int FO = 4
) (
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  lambda,
    input  logic [1:0]    mode,
    output logic [W:0]    shr,
    input  logic [W:0]    s1,
    output logic [WO-1:0] y
);
    // One extra bit keeps x+-lambda and -lambda exact for lambda up to 2^W-1.
    logic signed [W:0] xs, ls;
    assign xs = signed'({x[W-1], x});
    assign ls = signed'({1'b0, lambda});

    always_comb begin
        shr = '0;
        case (mode)
            SHRINK_SOFT: begin
                if (xs > ls)       shr = xs - ls;
                else if (xs < -ls) shr = xs + ls;
            end
            SHRINK_HARD: begin
                if (xs > ls || xs < -ls) shr = xs;
            end
            default: shr = xs;
        endcase
    end

    // Working width wide enough that rounding/shifting never overflows
    // before the saturation compare.
    localparam int EXT = (FO > F) ? FO - F : 0;
    localparam int CW  = W + WO + EXT + 2;
    localparam logic signed [CW-1:0] MAXV = {{(CW-WO+1){1'b0}}, {(WO-1){1'b1}}};
    localparam logic signed [CW-1:0] MINV = {{(CW-WO+1){1'b1}}, {(WO-1){1'b0}}};

    logic signed [CW-1:0] xw, xr;
    assign xw = {{(CW-W-1){s1[W]}}, s1};

    generate
        if (F > FO) begin : g_round
            localparam logic signed [CW-1:0] HALF = {{(CW-1){1'b0}}, 1'b1} << (F-FO-1);
            assign xr = (xw + HALF) >>> (F-FO);
        end else if (FO > F) begin : g_extend
            assign xr = xw <<< (FO-F);
        end else begin : g_same
            assign xr = xw;
        end
    endgenerate

    assign y = (xr > MAXV) ? MAXV[WO-1:0] :
               (xr < MINV) ? MINV[WO-1:0] : xr[WO-1:0];
endmodule

// File: rtl/fixed_shrink.sv
// fixed_shrink: two-stage pipelined soft/hard-shrink / bypass activation
// with valid/ready backpressure and tensor-aligned config reload.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fixed_shrink_if.slave (input stream, output stream, config)
// Stage 1 registers the shrink result, stage 2 the rounded/saturated
// output. Config is double-buffered: a handshake fills the shadow, and the
// shadow is promoted only when the beat counter sits at a tensor boundary.
module fixed_shrink
    import fixed_shrink_pkg::*;
#(
    parameter int  DATA_IN_0_PRECISION_0       = 8,
    parameter int  DATA_IN_0_PRECISION_1       = 4,
    parameter int  DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
    parameter int  DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int  DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int  DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int  DATA_OUT_0_PRECISION_0      = 8,
    parameter int  DATA_OUT_0_PRECISION_1      = 4,
    parameter real LAMBDA                      = 0.5,
    parameter int  DEFAULT_MODE                = 0
) (
    input logic          clk,
    input logic          rst,
    fixed_shrink_if.slave bus
);
    localparam int W      = DATA_IN_0_PRECISION_0;
    localparam int F      = DATA_IN_0_PRECISION_1;
    localparam int WO     = DATA_OUT_0_PRECISION_0;
    localparam int FO     = DATA_OUT_0_PRECISION_1;
    localparam int N      = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int BEATS  = beats_per_tensor(DATA_IN_0_TENSOR_SIZE_DIM_0, DATA_IN_0_TENSOR_SIZE_DIM_1,
                                             DATA_IN_0_PARALLELISM_DIM_0, DATA_IN_0_PARALLELISM_DIM_1);
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int STAGES = 2;
    localparam logic [W-1:0] LAM_RST  = W'(lambda_fix(LAMBDA, F));
    localparam logic [1:0]   MODE_RST = 2'(DEFAULT_MODE);

    logic [STAGES:1]      vld_pipe;
    logic [N-1:0][W:0]    shr_d, s1_data;
    logic [N-1:0][WO-1:0] cv_d, out_d;
    logic                 s1_last, out_last;
    logic [CNT_W-1:0]     beat_cnt;
    logic [W-1:0]         lam_act, lam_shd;
    logic [1:0]           mode_act, mode_shd;
    logic                 pending;
    logic s2_free, s1_free, commit, in_ready, in_fire, cfg_fire, last_beat;

    assign s2_free   = !vld_pipe[2] || bus.data_out_0_ready;
    assign s1_free   = !vld_pipe[1] || s2_free;
    // The promote cycle blocks input so the first beat of the new tensor
    // already sees the new config.
    assign commit    = pending && (beat_cnt == '0);
    assign in_ready  = s1_free && !commit;
    assign in_fire   = bus.data_in_0_valid && in_ready;
    assign cfg_fire  = bus.cfg_valid && !pending;
    assign last_beat = (beat_cnt == CNT_W'(BEATS-1));

    assign bus.data_in_0_ready  = in_ready;
    assign bus.cfg_ready        = !pending;
    assign bus.data_out_0       = out_d;
    assign bus.data_out_0_valid = vld_pipe[2];
    assign bus.data_out_0_last  = out_last;

    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            fixed_shrink_lane #(.W(W), .F(F), .WO(WO), .FO(FO)) u_lane (
                .x      (bus.data_in_0[i]),
                .lambda (lam_act),
                .mode   (mode_act),
                .shr    (shr_d[i]),
                .s1     (s1_data[i]),
                .y      (cv_d[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_data  <= '0;
            s1_last  <= 1'b0;
            out_d    <= '0;
            out_last <= 1'b0;
            beat_cnt <= '0;
            pending  <= 1'b0;
            lam_act  <= LAM_RST;
            mode_act <= MODE_RST;
            lam_shd  <= LAM_RST;
            mode_shd <= MODE_RST;
        end else begin
            if (s2_free) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    out_d    <= cv_d;
                    out_last <= s1_last;
                end
            end
            if (s1_free) begin
                vld_pipe[1] <= in_fire;
                if (in_fire) begin
                    s1_data <= shr_d;
                    s1_last <= last_beat;
                end
            end
            if (in_fire)
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            // cfg_fire needs !pending and commit needs pending: exclusive.
            if (cfg_fire) begin
                lam_shd  <= bus.cfg_lambda;
                mode_shd <= bus.cfg_mode;
                pending  <= 1'b1;
            end else if (commit) begin
                lam_act  <= lam_shd;
                mode_act <= mode_shd;
                pending  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fixed_shrink.sv
// tb_fixed_shrink: directed bench for fixed_shrink. Main instance uses
// default parameters; two bypass instances cover output-format conversion.
module tb_fixed_shrink;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fixed_shrink_if #(.N(1), .W(8), .WO(8)) bus ();
    fixed_shrink_if #(.N(1), .W(8), .WO(8)) bq ();
    fixed_shrink_if #(.N(1), .W(8), .WO(6)) bs ();

    fixed_shrink u_dut (.clk(clk), .rst(rst), .bus(bus));
    fixed_shrink #(.DATA_OUT_0_PRECISION_1(2), .DEFAULT_MODE(2)) u_q (.clk(clk), .rst(rst), .bus(bq));
    fixed_shrink #(.DATA_OUT_0_PRECISION_0(6), .DEFAULT_MODE(2)) u_s (.clk(clk), .rst(rst), .bus(bs));

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One isolated beat: accept now, nothing one cycle later, result two
    // cycles after accept.
    task automatic push_check(input string tag, input logic [7:0] x,
                              input logic [7:0] exp, input logic exp_last);
        bus.data_in_0       = x;
        bus.data_in_0_valid = 1'b1;
        chk({tag, ".rdy"}, 32'(bus.data_in_0_ready), 32'd1);
        tick;
        bus.data_in_0_valid = 1'b0;
        chk({tag, ".lat1"}, 32'(bus.data_out_0_valid), 32'd0);
        tick;
        chk({tag, ".vld"},  32'(bus.data_out_0_valid), 32'd1);
        chk({tag, ".data"}, 32'(bus.data_out_0),       32'(exp));
        chk({tag, ".last"}, 32'(bus.data_out_0_last),  32'(exp_last));
    endtask

    // Config at a tensor boundary: handshake, one blocked cycle, then live.
    task automatic cfg_commit(input string tag, input logic [1:0] m, input logic [7:0] l);
        bus.cfg_valid  = 1'b1;
        bus.cfg_mode   = m;
        bus.cfg_lambda = l;
        chk({tag, ".cfgrdy"}, 32'(bus.cfg_ready), 32'd1);
        tick;
        bus.cfg_valid = 1'b0;
        chk({tag, ".stall"},   32'(bus.data_in_0_ready), 32'd0);
        chk({tag, ".pending"}, 32'(bus.cfg_ready),       32'd0);
        tick;
        chk({tag, ".resume"},  32'(bus.data_in_0_ready), 32'd1);
        chk({tag, ".cfgfree"}, 32'(bus.cfg_ready),       32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, rcvd, c;
        bus.data_in_0 = '0; bus.data_in_0_valid = 1'b0; bus.data_out_0_ready = 1'b1;
        bus.cfg_valid = 1'b0; bus.cfg_mode = 2'd0; bus.cfg_lambda = '0;
        bq.data_in_0 = '0; bq.data_in_0_valid = 1'b0; bq.data_out_0_ready = 1'b1;
        bq.cfg_valid = 1'b0; bq.cfg_mode = 2'd0; bq.cfg_lambda = '0;
        bs.data_in_0 = '0; bs.data_in_0_valid = 1'b0; bs.data_out_0_ready = 1'b1;
        bs.cfg_valid = 1'b0; bs.cfg_mode = 2'd0; bs.cfg_lambda = '0;

        // Reset state
        rst = 1'b1;
        tick; tick;
        chk("rst.vld",    32'(bus.data_out_0_valid), 32'd0);
        chk("rst.data",   32'(bus.data_out_0),       32'd0);
        chk("rst.last",   32'(bus.data_out_0_last),  32'd0);
        chk("rst.cfgrdy", 32'(bus.cfg_ready),        32'd1);
        chk("rst.inrdy",  32'(bus.data_in_0_ready),  32'd1);
        chk("rst.q.vld",  32'(bq.data_out_0_valid),  32'd0);
        rst = 1'b0;

        // Output format conversion in bypass
        bq.data_in_0 = 8'h7F; bs.data_in_0 = 8'h7F;
        bq.data_in_0_valid = 1'b1; bs.data_in_0_valid = 1'b1;
        tick;
        bq.data_in_0 = 8'h06; bs.data_in_0 = 8'h80;
        tick;
        bq.data_in_0_valid = 1'b0; bs.data_in_0_valid = 1'b0;
        chk("t5.q.vld",  32'(bq.data_out_0_valid), 32'd1);
        chk("t5.q.7f",   32'(bq.data_out_0),       32'h20);
        chk("t5.s.7f",   32'(bs.data_out_0),       32'h1F);
        tick;
        chk("t5.q.06",   32'(bq.data_out_0),       32'h02);
        chk("t5.s.80",   32'(bs.data_out_0),       32'h20);

        // Soft, reset lambda = 8
        push_check("t1.20", 8'h20, 8'h18, 1'b0);
        push_check("t1.e0", 8'hE0, 8'hE8, 1'b0);
        push_check("t1.05", 8'h05, 8'h00, 1'b0);
        push_check("t1.08", 8'h08, 8'h00, 1'b0);
        push_check("t1.f8", 8'hF8, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) push_check("t1.pad", 8'h00, 8'h00, i == 4);

        // Hard, lambda = 8
        cfg_commit("t2", 2'd1, 8'h08);
        push_check("t2.09", 8'h09, 8'h09, 1'b0);
        push_check("t2.f8", 8'hF8, 8'h00, 1'b0);
        push_check("t2.80", 8'h80, 8'h80, 1'b0);
        for (int i = 0; i < 7; i++) push_check("t2.pad", 8'h00, 8'h00, i == 6);

        // Streaming under backpressure, soft lambda = 0 (identity)
        cfg_commit("t3", 2'd0, 8'h00);
        sent = 0; rcvd = 0; c = 0;
        while (rcvd < 10 && c < 40) begin
            bus.data_out_0_ready = !(c >= 3 && c <= 7);
            bus.data_in_0_valid  = (sent < 10);
            bus.data_in_0        = 8'(8'h10 + sent);
            #1;
            if (c < 10)
                chk("t3.inrdy", 32'(bus.data_in_0_ready), (c >= 3 && c <= 7) ? 32'd0 : 32'd1);
            if (c >= 3 && c <= 7) begin
                chk("t3.hold.vld",  32'(bus.data_out_0_valid), 32'd1);
                chk("t3.hold.data", 32'(bus.data_out_0),       32'h11);
            end
            if (bus.data_out_0_valid && bus.data_out_0_ready) begin
                chk("t3.data", 32'(bus.data_out_0),      32'(8'h10 + rcvd));
                chk("t3.last", 32'(bus.data_out_0_last), (rcvd == 9) ? 32'd1 : 32'd0);
                rcvd++;
            end
            if (bus.data_in_0_valid && bus.data_in_0_ready) sent++;
            @(posedge clk); #1;
            c++;
        end
        bus.data_in_0_valid  = 1'b0;
        bus.data_out_0_ready = 1'b1;
        chk("t3.count", 32'(rcvd), 32'd10);

        // Mid-tensor config waits for the boundary
        for (int i = 0; i < 5; i++) push_check("t4.pre", 8'(8'h20 + i), 8'(8'h20 + i), 1'b0);
        bus.cfg_valid = 1'b1; bus.cfg_mode = 2'd1; bus.cfg_lambda = 8'h7F;
        chk("t4.cfgrdy", 32'(bus.cfg_ready), 32'd1);
        tick;
        bus.cfg_valid = 1'b0;
        for (int i = 5; i < 9; i++) begin
            chk("t4.cfgbusy", 32'(bus.cfg_ready), 32'd0);
            push_check("t4.post", 8'(8'h20 + i), 8'(8'h20 + i), 1'b0);
        end
        chk("t4.cfgbusy9", 32'(bus.cfg_ready), 32'd0);
        bus.data_in_0 = 8'h29; bus.data_in_0_valid = 1'b1;
        chk("t4.rdy9", 32'(bus.data_in_0_ready), 32'd1);
        tick;
        bus.data_in_0_valid = 1'b0;
        chk("t4.stall",   32'(bus.data_in_0_ready), 32'd0);
        chk("t4.cfgbusy", 32'(bus.cfg_ready),       32'd0);
        tick;
        chk("t4.resume",  32'(bus.data_in_0_ready), 32'd1);
        chk("t4.cfgfree", 32'(bus.cfg_ready),       32'd1);
        chk("t4.vld9",    32'(bus.data_out_0_valid), 32'd1);
        chk("t4.data9",   32'(bus.data_out_0),       32'h29);
        chk("t4.last9",   32'(bus.data_out_0_last),  32'd1);
        push_check("t4.new", 8'h10, 8'h00, 1'b0);

        // Reset with two beats in flight and a pending config
        bus.cfg_valid = 1'b1; bus.cfg_mode = 2'd2; bus.cfg_lambda = 8'h00;
        bus.data_in_0 = 8'h30; bus.data_in_0_valid = 1'b1;
        chk("t6.cfgrdy", 32'(bus.cfg_ready), 32'd1);
        tick;
        bus.cfg_valid = 1'b0;
        bus.data_in_0 = 8'h31;
        chk("t6.pending", 32'(bus.cfg_ready),       32'd0);
        chk("t6.rdy2",    32'(bus.data_in_0_ready), 32'd1);
        tick;
        bus.data_in_0_valid = 1'b0;
        rst = 1'b1;
        chk("t6.inflight", 32'(bus.data_out_0_valid), 32'd1);
        tick;
        rst = 1'b0;
        chk("t6.vld",    32'(bus.data_out_0_valid), 32'd0);
        chk("t6.cfgrdy", 32'(bus.cfg_ready),        32'd1);
        chk("t6.data",   32'(bus.data_out_0),       32'd0);
        chk("t6.last",   32'(bus.data_out_0_last),  32'd0);
        push_check("t6.20", 8'h20, 8'h18, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fixed_shrink.md
# fixed_shrink

Pipelined, runtime-configurable shrink activation for signed fixed-point streams: soft-shrink, hard-shrink or bypass, with a threshold λ loadable at tensor boundaries. It rounds and saturates to an independent output format, and fully supports valid/ready backpressure. It sits in the activation layer of generated accelerators and succeeds the fixed-λ, combinational, non-stalling soft-shrink block.

## Interface
- DATA_IN_0_PRECISION_0, 8, input total width W
- DATA_IN_0_PRECISION_1, 4, input fractional bits F
- DATA_IN_0_TENSOR_SIZE_DIM_0 / _DIM_1, 10 / 1, tensor shape
- DATA_IN_0_PARALLELISM_DIM_0 / _DIM_1, 1 / 1, elements per beat; N = product
- DATA_OUT_0_PRECISION_0, 8, output total width WO
- DATA_OUT_0_PRECISION_1, 4, output fractional bits FO
- LAMBDA, 0.5, reset threshold (real); reset λ = $rtoi(LAMBDA·2^F)
- DEFAULT_MODE, 0, reset mode: 0 soft, 1 hard, 2/3 bypass
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- data_in_0  in  N×W  signed elements
- data_in_0_valid / data_in_0_ready  in / out  1  input handshake
- data_out_0  out  N×WO  results
- data_out_0_valid / data_out_0_ready  out / in  1  output handshake
- data_out_0_last  out  1  final beat of a tensor
- cfg_lambda  in  W  unsigned threshold, input format
- cfg_mode  in  2  mode
- cfg_valid / cfg_ready  in / out  1  config handshake

## Operation
- BEATS = (DIM_0/PAR_DIM_0)·(DIM_1/PAR_DIM_1). beat_cnt counts accepted input beats 0..BEATS-1 and wraps.
- Stage 1 (on input accept): compute per element in W+1-bit signed with λ zero-extended.
  - Soft: x<−λ → x+λ; x>λ → x−λ; else 0. |x|=λ gives 0.
  - Hard: |x|>λ → x; else 0.
  - Bypass: x.
  - The last flag is captured as beat_cnt==BEATS-1.
- Stage 2: convert F→FO.
  - Reducing fractional bits: round half-up (add 2^(F−FO−1), then arithmetic shift).
  - Extending fractional bits: left shift.
  - Then saturate to the signed WO range.
- Config:
  - cfg_ready = !pending. A cfg handshake loads the shadow registers and sets pending.
  - When pending && beat_cnt==0, that cycle forces data_in_0_ready=0, copies shadow to active, and clears pending.
  - A new config therefore never applies mid-tensor.
  - Beats already in the pipeline keep the config they were computed with.
- λ ≥ 2^(W−1) is legal. In soft or hard mode it zeroes every element.

## Timing
- Reset values: data_out_0_valid=0, data_out_0=0, data_out_0_last=0, cfg_ready=1, pending=0, beat_cnt=0, active λ and mode = parameter defaults, stage valids=0.
- Latency is 2 cycles from input accept to output valid when unstalled. Throughput is 1 beat per cycle.
- Ready logic: s2_free = !s2_valid || data_out_0_ready; s1_free = !s1_valid || s2_free; data_in_0_ready = s1_free && !(pending && beat_cnt==0). The combinational ready path is allowed.
- Data and last stay stable while valid && !ready. No beat is lost or duplicated, and order is preserved.
- An input accept and an output accept in the same cycle proceed at full rate.
- If a cfg handshake happens in the same cycle as the accept of beat BEATS-1, commit occurs on the next cycle and stalls input exactly one cycle.
- Reset mid-stream discards in-flight beats and any pending config. Outputs take their reset values on the following cycle.

## Structure
- Shared package fixed_shrink_pkg holds:
  - mode enum (SHRINK_SOFT, SHRINK_HARD, SHRINK_BYPASS);
  - a beats-per-tensor function;
  - a λ conversion function.
- Sub-module fixed_shrink_lane: combinational per-element shrink plus round/saturate, instantiated N times.
- The top level owns the pipeline registers, beat counter and config shadow.

## Test plan
Default parameters unless stated.
1. Soft mode, λ=8. Inputs 0x20, 0xE0, 0x05, 0x08, 0xF8 → outputs 0x18, 0xE8, 0x00, 0x00, 0x00. Each appears 2 cycles after accept.
2. cfg hard mode, λ=8. Inputs 0x09, 0xF8, 0x80 → 0x09, 0x00, 0x80.
3. Send 10 beats 0x10..0x19 in soft mode with λ=0 and data_out_0_ready low for cycles 3–7.
   - data_in_0_ready drops once 2 beats are held.
   - Output is 0x10..0x19 in order with no gaps or duplicates.
   - last is asserted only on 0x19.
4. Issue cfg (hard, λ=0x7F) after beat 4 of a tensor.
   - cfg_ready stays low until beat_cnt wraps.
   - data_in_0_ready is low exactly one cycle.
   - Beats 5–9 still use the soft result. The next tensor's 0x10 → 0x00.
5. Output rounding/saturation:
   - WO=8, FO=2, bypass: 0x7F → 0x20; 0x06 → 0x02.
   - WO=6, FO=4, bypass: 0x7F → 0x1F; 0x80 → 0x20.
6. Assert rst for 1 cycle with 2 beats in flight and a pending cfg.
   - Next cycle: data_out_0_valid=0, cfg_ready=1.
   - The mode is back to DEFAULT_MODE: 0x20 → 0x18.
